bht_sat_table_cp4: RTL and testbench
====================================

BHT_SAT_TABLE_CP4 -- requirements
Module: bht_sat_table_cp4

Interface
REQ-001 Parameter WIDTH, default 2, bit width of each saturating counter (legal: >=1).
REQ-002 Parameter DEPTH, default 32, number of counter entries (legal: power of 2, >=2).
REQ-003 Parameter INIT, default 2^(WIDTH-1)-1, reset and clear value of every entry (legal: 0..2^WIDTH-1).
REQ-004 Localparam IW = log2(DEPTH), the index width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 clear  input  1  synchronous flush of all entries to INIT.
REQ-008 rd_valid  input  1  lookup request this cycle.
REQ-009 rd_idx  input  IW  lookup entry index.
REQ-010 upd_valid  input  1  training update this cycle.
REQ-011 upd_idx  input  IW  update entry index.
REQ-012 upd_taken  input  1  resolved outcome; 1 = increment, 0 = decrement.
REQ-013 pred_valid  output  1  registered; high one cycle after an accepted lookup.
REQ-014 pred_ctr  output  WIDTH  registered counter value for the lookup.
REQ-015 pred_taken  output  1  MSB of pred_ctr.

Function
REQ-016 Storage: DEPTH x WIDTH register array; no other architectural state besides the output registers.
REQ-017 Lookup latency: exactly 1 cycle; rd_valid at edge N gives pred_valid=1 and pred_ctr=entry[rd_idx] after edge N.
REQ-018 rd_valid=0 at an edge: pred_valid=0 after it; pred_ctr holds its previous value.
REQ-019 Update: upd_valid=1 at an edge writes entry[upd_idx] <= sat(entry, upd_taken).
REQ-020 sat(): taken -> +1, clamped at 2^WIDTH-1; not taken -> -1, clamped at 0; no wrap-around in either direction.
REQ-021 Same-edge lookup and update to the same index: pred_ctr returns the post-update value (write-first bypass).
REQ-022 Same-edge lookup and update to different indices: pred_ctr returns the stored pre-edge value of rd_idx.
REQ-023 Only entry upd_idx changes on an update; all other entries hold.
REQ-024 clear=1 at an edge: all entries <= INIT; a same-edge update is discarded (clear wins).
REQ-025 clear=1 with rd_valid=1 at the same edge: pred_valid=1 and pred_ctr=INIT.
REQ-026 Indices are always in range (DEPTH is a power of 2); no out-of-range handling.
REQ-027 pred_taken is combinational from pred_ctr[WIDTH-1] only; no other combinational input-to-output paths.

Reset
REQ-028 rst_n=0 asynchronously sets all entries to INIT, pred_valid=0, and pred_ctr=INIT, independent of clk.
REQ-029 While rst_n=0, all inputs are ignored; the first edge after deassertion operates normally.
REQ-030 Reset asserted mid-operation discards any in-flight lookup; pred_valid drops immediately.

Verification
REQ-031 Reset (WIDTH=2, DEPTH=32, INIT=1): lookup each of idx 0..31 -> pred_ctr=1, pred_taken=0, pred_valid pulses once per request.
REQ-032 Saturation: 4 taken updates to idx 5, then lookup -> pred_ctr=3; 5 not-taken updates, then lookup -> pred_ctr=0, no wrap.
REQ-033 Bypass: idx 7 holds 1; same-edge upd_taken=1 to idx 7 with lookup of idx 7 -> pred_ctr=2, pred_taken=1; same edge with lookup of idx 8 -> pred_ctr=1 (INIT).
REQ-034 Clear priority: idx 3 holds 3; same-edge clear with upd_taken=1 to idx 3 and lookup of idx 3 -> pred_ctr=1; next lookup of idx 3 -> 1.
REQ-035 Async reset: drop rst_n mid-cycle after entries are trained -> pred_valid=0 before the next edge; all entries read back INIT.
REQ-036 Parameter sweep: WIDTH=3, DEPTH=4, INIT=3 -> 8 taken updates saturate at 7; random update/lookup stream matches a reference model each cycle.

Source files
------------

// File: rtl/bht_sat_table_cp4.sv
// Branch history table of DEPTH saturating counters with a one-cycle registered lookup,
// a write-first bypass for same-edge updates, and a synchronous flush.

module bht_sat_entry #(
   parameter int               WIDTH  = 2,
   parameter logic [WIDTH-1:0] INIT_V = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             upd_en,
   input  logic             upd_taken,
   output logic [WIDTH-1:0] ctr,
   output logic [WIDTH-1:0] ctr_nxt
);
   // ctr_nxt is exported so the lookup path can bypass a same-edge update
   always_comb begin
      ctr_nxt = ctr;
      if (upd_taken) begin
         if (ctr != '1) ctr_nxt = ctr + 1'b1;
      end else if (ctr != '0) begin
         ctr_nxt = ctr - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ctr <= INIT_V;
      else if (clear)  ctr <= INIT_V;
      else if (upd_en) ctr <= ctr_nxt;
   end
endmodule

module bht_sat_table_cp4 #(
   parameter  int WIDTH = 2,
   parameter  int DEPTH = 32,
   parameter  int INIT  = 2**(WIDTH-1)-1,
   localparam int IW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             rd_valid,
   input  logic [IW-1:0]    rd_idx,
   input  logic             upd_valid,
   input  logic [IW-1:0]    upd_idx,
   input  logic             upd_taken,
   output logic             pred_valid,
   output logic [WIDTH-1:0] pred_ctr,
   output logic             pred_taken
);
   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

   logic [DEPTH-1:0][WIDTH-1:0] ctr_q;
   logic [DEPTH-1:0][WIDTH-1:0] ctr_nxt;
   logic                        rd_hit;

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      bht_sat_entry #(.WIDTH(WIDTH), .INIT_V(INIT_V)) u_ent (
         .clk       (clk),
         .rst_n     (rst_n),
         .clear     (clear),
         .upd_en    (upd_valid && (upd_idx == IW'(i))),
         .upd_taken (upd_taken),
         .ctr       (ctr_q[i]),
         .ctr_nxt   (ctr_nxt[i])
      );
   end

   assign rd_hit = upd_valid && (upd_idx == rd_idx);

   // Flush beats bypass beats stored value, matching what the array holds after the edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_valid <= 1'b0;
         pred_ctr   <= INIT_V;
      end else begin
         pred_valid <= rd_valid;
         if (rd_valid) begin
            if (clear)       pred_ctr <= INIT_V;
            else if (rd_hit) pred_ctr <= ctr_nxt[rd_idx];
            else             pred_ctr <= ctr_q[rd_idx];
         end
      end
   end

   assign pred_taken = pred_ctr[WIDTH-1];
endmodule

// File: tb/tb_bht_sat_table_cp4.sv
// Bench for bht_sat_table_cp4: a default-size table and a WIDTH=3/DEPTH=4/INIT=3 table,
// both checked every cycle against an integer reference model plus directed literal checks.

module tb_bht_sat_table_cp4;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   // table A: WIDTH=2 DEPTH=32 INIT=1
   logic       a_clear = 0, a_rd_valid = 0, a_upd_valid = 0, a_upd_taken = 0;
   logic [4:0] a_rd_idx = 0, a_upd_idx = 0;
   logic       a_pred_valid, a_pred_taken;
   logic [1:0] a_pred_ctr;

   // table B: WIDTH=3 DEPTH=4 INIT=3
   logic       b_clear = 0, b_rd_valid = 0, b_upd_valid = 0, b_upd_taken = 0;
   logic [1:0] b_rd_idx = 0, b_upd_idx = 0;
   logic       b_pred_valid, b_pred_taken;
   logic [2:0] b_pred_ctr;

   bht_sat_table_cp4 #(.WIDTH(2), .DEPTH(32), .INIT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(a_clear),
      .rd_valid(a_rd_valid), .rd_idx(a_rd_idx),
      .upd_valid(a_upd_valid), .upd_idx(a_upd_idx), .upd_taken(a_upd_taken),
      .pred_valid(a_pred_valid), .pred_ctr(a_pred_ctr), .pred_taken(a_pred_taken)
   );

   bht_sat_table_cp4 #(.WIDTH(3), .DEPTH(4), .INIT(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(b_clear),
      .rd_valid(b_rd_valid), .rd_idx(b_rd_idx),
      .upd_valid(b_upd_valid), .upd_idx(b_upd_idx), .upd_taken(b_upd_taken),
      .pred_valid(b_pred_valid), .pred_ctr(b_pred_ctr), .pred_taken(b_pred_taken)
   );

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input bit up, input int maxv);
      if (up) return (v + 1 > maxv) ? maxv : v + 1;
      return (v - 1 < 0) ? 0 : v - 1;
   endfunction

   // reference model: plain integer tables, expected outputs after each edge
   int ma[32];
   int mb[4];
   int ea_v, ea_c, eb_v, eb_c;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         foreach (ma[i]) ma[i] = 1;
         foreach (mb[i]) mb[i] = 3;
         ea_v = 0; ea_c = 1;
         eb_v = 0; eb_c = 3;
      end else begin
         ea_v = a_rd_valid;
         if (a_rd_valid)
            ea_c = a_clear ? 1 :
                   (a_upd_valid && a_upd_idx == a_rd_idx) ? sat(ma[a_rd_idx], a_upd_taken, 3) :
                   ma[a_rd_idx];
         if (a_clear) foreach (ma[i]) ma[i] = 1;
         else if (a_upd_valid) ma[a_upd_idx] = sat(ma[a_upd_idx], a_upd_taken, 3);

         eb_v = b_rd_valid;
         if (b_rd_valid)
            eb_c = b_clear ? 3 :
                   (b_upd_valid && b_upd_idx == b_rd_idx) ? sat(mb[b_rd_idx], b_upd_taken, 7) :
                   mb[b_rd_idx];
         if (b_clear) foreach (mb[i]) mb[i] = 3;
         else if (b_upd_valid) mb[b_upd_idx] = sat(mb[b_upd_idx], b_upd_taken, 7);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("a_valid", int'(a_pred_valid), ea_v);
         chk("a_ctr",   int'(a_pred_ctr),   ea_c);
         chk("a_taken", int'(a_pred_taken), (ea_c >= 2) ? 1 : 0);
         chk("b_valid", int'(b_pred_valid), eb_v);
         chk("b_ctr",   int'(b_pred_ctr),   eb_c);
         chk("b_taken", int'(b_pred_taken), (eb_c >= 4) ? 1 : 0);
      end
   end

   // drive one cycle on table A from a negedge; returns at the following negedge
   task automatic cyc_a(input bit clr, input bit rv, input int ri,
                        input bit uv, input int ui, input bit ut);
      a_clear = clr; a_rd_valid = rv; a_rd_idx = 5'(ri);
      a_upd_valid = uv; a_upd_idx = 5'(ui); a_upd_taken = ut;
      @(posedge clk); @(negedge clk);
      a_clear = 0; a_rd_valid = 0; a_upd_valid = 0;
   endtask

   task automatic cyc_b(input bit clr, input bit rv, input int ri,
                        input bit uv, input int ui, input bit ut);
      b_clear = clr; b_rd_valid = rv; b_rd_idx = 2'(ri);
      b_upd_valid = uv; b_upd_idx = 2'(ui); b_upd_taken = ut;
      @(posedge clk); @(negedge clk);
      b_clear = 0; b_rd_valid = 0; b_upd_valid = 0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_a_valid", int'(a_pred_valid), 0);
      chk("rst_a_ctr",   int'(a_pred_ctr),   1);
      chk("rst_b_ctr",   int'(b_pred_ctr),   3);
      cmp_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // every entry reads INIT; valid is a single-cycle pulse per request
      for (int i = 0; i < 32; i++) begin
         cyc_a(0, 1, i, 0, 0, 0);
         chk("init_ctr",   int'(a_pred_ctr),   1);
         chk("init_taken", int'(a_pred_taken), 0);
         chk("init_valid", int'(a_pred_valid), 1);
         cyc_a(0, 0, 0, 0, 0, 0);
         chk("init_pulse", int'(a_pred_valid), 0);
      end

      // saturation both ways on idx 5
      for (int i = 0; i < 4; i++) cyc_a(0, 0, 0, 1, 5, 1);
      cyc_a(0, 1, 5, 0, 0, 0);
      chk("sat_hi", int'(a_pred_ctr), 3);
      for (int i = 0; i < 5; i++) cyc_a(0, 0, 0, 1, 5, 0);
      cyc_a(0, 1, 5, 0, 0, 0);
      chk("sat_lo", int'(a_pred_ctr), 0);
      cyc_a(0, 0, 0, 0, 0, 0);
      chk("hold_ctr", int'(a_pred_ctr), 0);

      // write-first bypass on idx 7, then a lookup of a different index on an update edge
      cyc_a(0, 1, 7, 1, 7, 1);
      chk("byp_ctr",   int'(a_pred_ctr),   2);
      chk("byp_taken", int'(a_pred_taken), 1);
      cyc_a(0, 1, 8, 1, 7, 1);
      chk("nobyp_ctr", int'(a_pred_ctr), 1);
      cyc_a(0, 1, 7, 1, 8, 0);
      chk("byp_stored", int'(a_pred_ctr), 3);

      // clear wins over a same-edge update and reads back INIT
      cyc_a(0, 0, 0, 1, 3, 1);
      cyc_a(0, 0, 0, 1, 3, 1);
      cyc_a(0, 1, 3, 0, 0, 0);
      chk("pre_clr", int'(a_pred_ctr), 3);
      cyc_a(1, 1, 3, 1, 3, 1);
      chk("clr_ctr",   int'(a_pred_ctr),   1);
      chk("clr_valid", int'(a_pred_valid), 1);
      cyc_a(0, 1, 3, 0, 0, 0);
      chk("post_clr3", int'(a_pred_ctr), 1);
      cyc_a(0, 1, 7, 0, 0, 0);
      chk("post_clr7", int'(a_pred_ctr), 1);

      // train, then assert reset mid-cycle with a valid prediction showing
      cyc_a(0, 0, 0, 1, 10, 1);
      cyc_a(0, 0, 0, 1, 10, 1);
      cyc_a(0, 1, 10, 0, 0, 0);
      chk("pre_rst", int'(a_pred_ctr), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(a_pred_valid), 0);
      chk("arst_ctr",   int'(a_pred_ctr),   1);
      @(negedge clk);
      cyc_a(0, 1, 10, 1, 10, 1);
      chk("rst_ignore", int'(a_pred_valid), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         cyc_a(0, 1, i, 0, 0, 0);
         chk("rst_readback", int'(a_pred_ctr), 1);
      end

      // second geometry: saturate at 7, MSB threshold at 4
      for (int i = 0; i < 8; i++) cyc_b(0, 0, 0, 1, 2, 1);
      cyc_b(0, 1, 2, 0, 0, 0);
      chk("b_sat7",   int'(b_pred_ctr),   7);
      chk("b_taken7", int'(b_pred_taken), 1);
      cyc_b(0, 1, 0, 0, 0, 0);
      chk("b_init0",  int'(b_pred_ctr),   3);
      chk("b_taken0", int'(b_pred_taken), 0);
      cyc_b(0, 1, 0, 1, 0, 1);
      chk("b_byp4",   int'(b_pred_taken), 1);

      // random mix, checked each cycle by the model
      for (int n = 0; n < 400; n++)
         cyc_b(($urandom_range(0, 15) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
